// File: rtl/acc_burst_arbiter.sv
// Burst arbiter that lets NUM_REQ macro-result requesters share one accumulation
// buffer. Requesters are picked round-robin and own the beat stream for one
// column block (MACRO_COLUMN beats). The data, valid and ready paths pass straight
// through with no registers. A 2-deep ID FIFO records which requester owns each
// block that has gone into the buffer, so the result leaving the buffer can be
// tagged with blk_id.
//
// Ports:
//   clk, rst            single clock (rising edge); asynchronous active-high reset
//   req_data/vld/rdy    per-requester beat streams (requester i at [i*FP_WIDTH +: FP_WIDTH])
//   acc_data/vld/rdy    granted beat stream to the accumulation buffer
//   blk_vld, blk_rdy    observed result handshake at the buffer output (pops the ID FIFO)
//   blk_id              owner of the result at the buffer output (0 when FIFO empty)
//   blk_done_cnt        completed-block counter
//
// Build option: define ACC_ARB_DONE_CNT_EN to make blk_done_cnt count FIFO pops.
// Without it, blk_done_cnt is tied to 0.
module acc_burst_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MACRO_COLUMN = 4,
  parameter int unsigned FP_WIDTH     = 16,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*FP_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_vld,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic [FP_WIDTH-1:0]         acc_data,
  output logic                        acc_vld,
  input  logic                        acc_rdy,
  input  logic                        blk_vld,
  input  logic                        blk_rdy,
  output logic [ID_W-1:0]             blk_id,
  output logic [15:0]                 blk_done_cnt
);

  localparam int unsigned    CNT_W     = $clog2(MACRO_COLUMN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MACRO_COLUMN - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   fifo_q [2];
  logic [ID_W-1:0]   fifo_d [2];
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              beat, push, pop, fifo_full, found;
  logic [ID_W-1:0]   sel;
  int unsigned       idx;

  // Round-robin search starting just after the last completed owner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % NUM_REQ;
      if (!found && req_vld[idx[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[ID_W-1:0];
      end
    end
  end

  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign pop       = blk_vld & blk_rdy & (fifo_cnt_q != 2'd0);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    push       = 1'b0;
    beat       = 1'b0;
    req_rdy    = '0;
    acc_vld    = 1'b0;
    acc_data   = req_data[grant_q*FP_WIDTH +: FP_WIDTH];
    unique case (state_q)
      StIdle: begin
        // A block whose ID has nowhere to go is never started.
        if (found && !fifo_full) begin
          grant_d = sel;
          state_d = StBurst;
        end
      end
      StBurst: begin
        acc_vld          = req_vld[grant_q];
        req_rdy[grant_q] = acc_rdy;
        beat             = acc_vld & acc_rdy;
        if (beat) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            push       = 1'b1;
            last_d     = grant_q;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-entry ID FIFO with the head at entry 0. A push can only arrive when
  // the FIFO is not full, because no burst starts while it is full.
  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10: begin
        fifo_d[fifo_cnt_q[0]] = grant_q;
        fifo_cnt_d            = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0]  = fifo_q[1];
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        fifo_d[0] = (fifo_cnt_q == 2'd1) ? grant_q : fifo_q[1];
        fifo_d[1] = grant_q;
      end
      default: ;
    endcase
  end

  assign blk_id = (fifo_cnt_q != 2'd0) ? fifo_q[0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      last_q     <= LAST_INIT;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      fifo_q     <= fifo_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

`ifdef ACC_ARB_DONE_CNT_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign blk_done_cnt = done_cnt_q;
`else
  assign blk_done_cnt = 16'd0;
`endif

endmodule

// File: doc/acc_burst_arbiter.md
ACC_BURST_ARBITER -- requirements
Module: acc_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of macro-result requesters sharing one accumulation buffer.
REQ-002 SHALL have parameter MACRO_COLUMN, default 4, beats per column block (one accumulation burst).
REQ-003 SHALL have parameter FP_WIDTH, default 16, width of one FP result beat; ID_W = $clog2(NUM_REQ) is derived.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_data  input  NUM_REQ*FP_WIDTH  per-requester result beat; requester i occupies bits [i*FP_WIDTH +: FP_WIDTH].
REQ-007 SHALL have ports req_vld  input  NUM_REQ and req_rdy  output  NUM_REQ  per-requester valid/ready.
REQ-008 SHALL have ports acc_data  output  FP_WIDTH, acc_vld  output  1, acc_rdy  input  1  beat stream to the accumulation buffer.
REQ-009 SHALL have ports blk_vld  input  1 and blk_rdy  input  1  observed result handshake of the accumulation buffer output.
REQ-010 SHALL have port blk_id  output  ID_W  requester owning the result currently at the accumulation buffer output.
REQ-011 SHALL have port blk_done_cnt  output  16  completed-block counter (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE and BURST.
REQ-013 In IDLE, SHALL select the first asserted req_vld searching round-robin from index (last_grant+1) mod NUM_REQ, register it as grant_id, and enter BURST next cycle; no selection while ID FIFO full.
REQ-014 In IDLE, all req_rdy and acc_vld SHALL be 0.
REQ-015 In BURST, acc_data = req_data[grant_id], acc_vld = req_vld[grant_id], req_rdy[grant_id] = acc_rdy; all other req_rdy = 0 (combinational pass-through, zero added latency).
REQ-016 SHALL count beats (acc_vld & acc_rdy) in a counter of width $clog2(MACRO_COLUMN)+1; on beat MACRO_COLUMN SHALL clear counter, push grant_id into ID FIFO, set last_grant = grant_id, return to IDLE.
REQ-017 A burst SHALL never be preempted; deasserted req_vld[grant_id] mid-burst holds BURST with counter unchanged.
REQ-018 ID FIFO SHALL be depth 2; blk_id = FIFO head; pop on blk_vld & blk_rdy; simultaneous push and pop SHALL both take effect.
REQ-019 Pop on empty FIFO SHALL be ignored and blk_id SHALL hold 0.
REQ-020 Minimum grant-to-grant gap SHALL be MACRO_COLUMN+1 cycles (one IDLE arbitration cycle per burst).

Reset
REQ-021 On rst: state IDLE, beat counter 0, grant_id 0, last_grant NUM_REQ-1 (so requester 0 wins first), FIFO empty, blk_id 0, blk_done_cnt 0, acc_vld 0, req_rdy all 0.
REQ-022 Reset asserted mid-burst SHALL abandon the partial burst; no ID pushed.

Configuration
REQ-023 With ACC_ARB_DONE_CNT_EN defined, blk_done_cnt SHALL increment (wrapping at 16'hFFFF->0) on every FIFO pop.
REQ-024 Without ACC_ARB_DONE_CNT_EN, blk_done_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-025 After reset, req_vld=4'b1111, acc_rdy=1 -> grants 0,1,2,3,0 in order, each 4 beats, 1 IDLE cycle between bursts.
REQ-026 req_vld=4'b0100 only -> grant_id=2 one cycle after IDLE sample; acc_data equals req_data[47:32] on all 4 beats.
REQ-027 BURST with acc_rdy toggling 1,0,1,0... -> exactly 4 accepted beats over 8 cycles, req_rdy[grant] mirrors acc_rdy, others 0.
REQ-028 Two bursts complete with blk_rdy=0 -> FIFO full, third requester not granted until one blk_vld&blk_rdy pop; blk_id shows first ID then second.
REQ-029 rst pulsed after 2 beats of a burst -> all outputs at REQ-021 values, next grant goes to requester 0.
REQ-030 With ACC_ARB_DONE_CNT_EN, 3 pops -> blk_done_cnt=3; without it -> blk_done_cnt=0.
